bus_fifo_drain: RTL and testbench
=================================

# bus_fifo_drain

Read-side stage for the 33-bit packet FIFO (32-bit data plus pktend flag, non-showahead, one-cycle read latency, no underflow protection). It issues FIFO reads, absorbs the read latency in a 2-entry skid buffer, and presents a valid/ready word stream with a packet-end marker to the downstream bus/USB writer. Optionally it splits over-long packets.

## Interface
- MAXPKT, 256: maximum words per emitted packet when splitting is compiled in. Range 2..65535.
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- fifo_data_i  in  32  FIFO q data, valid the cycle after fifo_re_o.
- fifo_pktend_i  in  1  FIFO q pktend bit, same timing as fifo_data_i.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_re_o  out  1  FIFO read request.
- data_o  out  32  output word.
- pktend_o  out  1  last word of packet; qualified by valid_o.
- valid_o  out  1  data_o and pktend_o hold a word.
- ready_i  in  1  downstream accepts the word this cycle.
- pkt_cnt_o  out  16  packets emitted (pktend words transferred), wraps at 65535 -> 0.
- busy_o  out  1  buffer occupied or read in flight.

## Operation
- State registers:
  - occ (0..2): buffer occupancy.
  - inflight (0/1): read issued last cycle.
  - 2-entry buffer: 33 bits per entry, read and write pointers.
  - wcnt (16 bit): words transferred in the current packet.
  - pkt_cnt.
- Transfer: xfer = valid_o & ready_i.
- Read issue (combinational): fifo_re_o = !fifo_empty_i & (occ + inflight - xfer < 2).
  - fifo_re_o is never high while fifo_empty_i is high.
- inflight <= fifo_re_o.
- Capture: when inflight is 1, {fifo_pktend_i, fifo_data_i} is written into the buffer at the write pointer.
- Occupancy update: occ_next = occ + inflight - xfer. Simultaneous capture and transfer leaves occ unchanged.
- Output: valid_o = (occ != 0). data_o is the head entry's data.
- pktend_o = head pktend | forced split (see Configuration).
- Data and pktend must not change while valid_o is high and ready_i is low.
- On a transfer:
  - wcnt increments, or clears to 0 if pktend_o is 1.
  - pkt_cnt increments when pktend_o is 1.
- busy_o = (occ != 0) | inflight.
- Overflow of the skid buffer is impossible by construction. The bench asserts occ never exceeds 2.
- Reset (asynchronous, any time, including mid-packet with a read in flight):
  - occ, inflight, pointers, wcnt and pkt_cnt go to 0.
  - Outputs: valid_o = 0, pktend_o = 0, data_o = 0, fifo_re_o = 0 while rst_n_i is low, pkt_cnt_o = 0, busy_o = 0.
  - Data returned by a read issued before reset is discarded.
  - The FIFO is cleared separately by its own sclr.

## Timing
- Latency: fifo_re_o high in cycle N -> word captured at the end of N+1 -> valid_o high in cycle N+2.
- Throughput: one word per cycle sustained while the FIFO is non-empty and ready_i is high.
- Backpressure: ready_i low for k cycles stops reads within one cycle. At most 2 words are held, and no word is lost or duplicated.
- Release: ready_i rising again gives a transfer in the same cycle and a read in the same cycle.
- fifo_re_o has a combinational path from fifo_empty_i and ready_i. All other outputs are registered.

## Configuration
- BUS_FIFO_DRAIN_MAXPKT_EN defined:
  - pktend_o is forced to 1 on the word where wcnt == MAXPKT-1, even if the FIFO pktend bit is 0.
  - wcnt then clears, and the following words start a new packet.
  - A FIFO pktend on that same word yields a single pktend.
- BUS_FIFO_DRAIN_MAXPKT_EN undefined:
  - pktend_o equals the stored FIFO bit. No forced split.
  - wcnt remains for pkt accounting only, and MAXPKT is ignored.

## Test plan
- Reset idle: rst_n_i low, then high with FIFO empty -> valid_o=0, fifo_re_o=0, pkt_cnt_o=0, busy_o=0.
- Streaming: 10 words, the last with pktend, ready_i held high -> first valid_o 2 cycles after the first fifo_re_o. All 10 words are then emitted in 10 consecutive cycles, with pktend_o only on word 10 and pkt_cnt_o=1.
- Backpressure: ready_i low for 5 cycles mid-stream -> at most 2 reads after ready_i falls. data_o is stable throughout, and the output sequence is identical to the input.
- Forced split (macro on, MAXPKT=4): 9 words, pktend only on word 9 -> pktend_o on words 4, 8 and 9, pkt_cnt_o=3.
- Reset mid-operation: assert rst_n_i low in the cycle after fifo_re_o -> the captured word is dropped, valid_o stays 0, and there is no spurious transfer after release.
- Wrap: 65536 single-word packets -> pkt_cnt_o returns to 0.

Source files
------------

// File: rtl/bus_fifo_drain.sv
// Read-side drain stage for the 33-bit packet FIFO: issues reads, absorbs the read latency in a
// 2-entry skid buffer and emits a valid/ready word stream. Optional split: BUS_FIFO_DRAIN_MAXPKT_EN.
module bus_fifo_drain #(
  parameter int MAXPKT = 256
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] fifo_data_i,
  input  logic        fifo_pktend_i,
  input  logic        fifo_empty_i,
  output logic        fifo_re_o,
  output logic [31:0] data_o,
  output logic        pktend_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [15:0] pkt_cnt_o,
  output logic        busy_o
);

`ifdef BUS_FIFO_DRAIN_MAXPKT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif
  localparam logic [15:0] WCNT_LAST = 16'(MAXPKT - 1);

  logic [1:0]  occ_r;
  logic        inflight_r;
  logic [32:0] buf_r [2];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [15:0] wcnt_r;
  logic [15:0] pkt_cnt_r;

  logic [32:0] head_s;
  logic        split_s;
  logic        xfer_s;
  logic        re_s;
  logic [2:0]  level_s;
  logic [1:0]  occ_next_s;

  // Head selection, transfer detect and read-issue decision
  always_comb begin
    head_s     = buf_r[rd_ptr_r];
    split_s    = SPLIT_EN & (wcnt_r == WCNT_LAST);
    xfer_s     = valid_o & ready_i;
    // Words that will be held or in flight after this edge if no new read is issued
    level_s    = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, xfer_s};
    re_s       = rst_n_i & ~fifo_empty_i & (level_s < 3'd2);
    occ_next_s = occ_r + {1'b0, inflight_r} - {1'b0, xfer_s};
  end

  assign valid_o   = (occ_r != 2'd0);
  assign data_o    = head_s[31:0];
  assign pktend_o  = valid_o & (head_s[32] | split_s);
  assign fifo_re_o = re_s;
  assign busy_o    = valid_o | inflight_r;
  assign pkt_cnt_o = pkt_cnt_r;

  // Occupancy, in-flight flag, skid buffer storage and pointers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      buf_r[0]   <= 33'd0;
      buf_r[1]   <= 33'd0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
    end else begin
      occ_r      <= occ_next_s;
      inflight_r <= re_s;
      if (inflight_r) begin
        buf_r[wr_ptr_r] <= {fifo_pktend_i, fifo_data_i};
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (xfer_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

  // Per-packet word count and emitted-packet counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wcnt_r    <= 16'd0;
      pkt_cnt_r <= 16'd0;
    end else if (xfer_s) begin
      if (pktend_o) begin
        wcnt_r    <= 16'd0;
        pkt_cnt_r <= pkt_cnt_r + 16'd1;
      end else begin
        wcnt_r    <= wcnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_fifo_drain.sv
// Scoreboard bench for bus_fifo_drain: a queue-based FIFO model feeds the DUT, expected words
// are queued at push time and a separate monitor compares every accepted output word.
module tb_bus_fifo_drain;
  localparam int MAXPKT_TB = 4;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [31:0] fifo_data_i;
  logic        fifo_pktend_i;
  logic        fifo_empty_i;
  logic        fifo_re_o;
  logic [31:0] data_o;
  logic        pktend_o;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] pkt_cnt_o;
  logic        busy_o;

  always #5 clk = ~clk;

  bus_fifo_drain #(.MAXPKT(MAXPKT_TB)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .fifo_data_i(fifo_data_i), .fifo_pktend_i(fifo_pktend_i),
    .fifo_empty_i(fifo_empty_i), .fifo_re_o(fifo_re_o), .data_o(data_o), .pktend_o(pktend_o),
    .valid_o(valid_o), .ready_i(ready_i), .pkt_cnt_o(pkt_cnt_o), .busy_o(busy_o)
  );

  int          checks = 0;
  int          errors = 0;
  logic [32:0] fifo_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] pend;
  bit          pend_v = 1'b0;
  int          outstanding = 0;
  logic [15:0] model_wc = 16'd0;
  logic [15:0] mon_pkts = 16'd0;
  bit          hold_v = 1'b0;
  logic [32:0] hold_w;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO content plus expected output word with packet end rules applied
  function automatic void push_word(input logic [31:0] d, input logic p);
    logic e;
`ifdef BUS_FIFO_DRAIN_MAXPKT_EN
    e = p | (model_wc == 16'(MAXPKT_TB - 1));
`else
    e = p;
`endif
    model_wc = e ? 16'd0 : model_wc + 16'd1;
    fifo_q.push_back({p, d});
    exp_q.push_back({e, d});
  endfunction

  // FIFO model: one-cycle read latency, data shown during the cycle after the read
  always @(negedge clk) begin
    #1;
    if (pend_v) {fifo_pktend_i, fifo_data_i} = pend;
    else begin
      fifo_data_i   = $urandom;
      fifo_pktend_i = 1'($urandom_range(0, 1));
    end
    pend_v       = 1'b0;
    fifo_empty_i = (fifo_q.size() == 0);
    #1;
    if (fifo_re_o === 1'b1) begin
      if (fifo_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_while_empty at %0t", $time);
      end else begin
        pend = fifo_q.pop_front();
        pend_v = 1'b1;
        outstanding++;
      end
    end
  end

  // Monitor: compares each accepted word, checks hold stability and buffering bound
  always @(negedge clk) begin
    logic [32:0] w;
    #3;
    if (rst_n_i !== 1'b1) hold_v = 1'b0;
    else begin
      if (hold_v) begin
        chk("hold_valid", 64'(valid_o), 64'd1);
        chk("hold_word", 64'({pktend_o, data_o}), 64'(hold_w));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_xfer: got %0h expected none at %0t", {pktend_o, data_o}, $time);
        end else begin
          w = exp_q.pop_front();
          chk("word", 64'({pktend_o, data_o}), 64'(w));
          chk("pkt_cnt", 64'(pkt_cnt_o), 64'(mon_pkts));
          if (w[32]) mon_pkts = mon_pkts + 16'd1;
          outstanding--;
        end
      end
      hold_v = valid_o && !ready_i;
      hold_w = {pktend_o, data_o};
      chk("outstanding_le2", 64'(outstanding <= 2), 64'd1);
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 1000) begin
      @(negedge clk); #4; n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy_o) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    int first_re, first_v, first_x, last_x, nx, reads, pushed;
    bit found;
    rst_n_i = 1'b0; ready_i = 1'b0; fifo_empty_i = 1'b1;
    fifo_data_i = 32'd0; fifo_pktend_i = 1'b0;

    // Reset idle, with a non-empty FIFO during reset
    repeat (2) @(negedge clk);
    fifo_q.push_back(33'h1_1234_5678);
    @(negedge clk); #4;
    chk("rst_re", 64'(fifo_re_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
    chk("rst_data", 64'({pktend_o, data_o}), 64'd0);
    @(negedge clk); fifo_q.delete();
    @(negedge clk); rst_n_i = 1'b1; ready_i = 1'b1;
    repeat (2) @(negedge clk);
    #4;
    chk("idle_valid", 64'(valid_o), 64'd0);
    chk("idle_re", 64'(fifo_re_o), 64'd0);
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("idle_pkt_cnt", 64'(pkt_cnt_o), 64'd0);

    // Streaming: 10 words, pktend on the last
    @(negedge clk);
    for (int i = 1; i <= 10; i++) push_word(32'hA000_0000 + 32'(i), i == 10);
    first_re = -1; first_v = -1; first_x = -1; last_x = -1; nx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #4;
      if (fifo_re_o && first_re < 0) first_re = cyc;
      if (valid_o && first_v < 0) first_v = cyc;
      if (valid_o && ready_i) begin
        nx++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      @(negedge clk);
    end
    chk("stream_first_re", 64'(first_re), 64'd0);
    chk("stream_latency", 64'(first_v - first_re), 64'd2);
    chk("stream_count", 64'(nx), 64'd10);
    chk("stream_back_to_back", 64'(last_x - first_x), 64'd9);
`ifdef BUS_FIFO_DRAIN_MAXPKT_EN
    chk("stream_pkt_cnt", 64'(pkt_cnt_o), 64'd3);
`else
    chk("stream_pkt_cnt", 64'(pkt_cnt_o), 64'd1);
`endif
    wait_idle("stream");

    // Backpressure: 5 cycles of ready low mid-stream
    @(negedge clk);
    for (int i = 0; i < 20; i++) push_word($urandom, i == 19);
    repeat (6) @(negedge clk);
    ready_i = 1'b0; reads = 0;
    for (int c = 0; c < 5; c++) begin
      #4;
      if (fifo_re_o) reads++;
      @(negedge clk);
    end
    ready_i = 1'b1;
    #4;
    chk("bp_reads_le2", 64'(reads <= 2), 64'd1);
    chk("release_xfer", 64'(valid_o & ready_i), 64'd1);
    chk("release_read", 64'(fifo_re_o), 64'd1);
    wait_idle("backpressure");

    // Split pattern (9 words, pktend only on the last) then random traffic
    @(negedge clk);
    for (int i = 1; i <= 9; i++) push_word(32'hB000_0000 + 32'(i), i == 9);
    pushed = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ready_i = ($urandom_range(0, 3) != 0);
      if (pushed < 300 && $urandom_range(0, 3) != 0) begin
        push_word($urandom, $urandom_range(0, 5) == 0);
        pushed++;
      end
    end
    @(negedge clk); ready_i = 1'b1;
    wait_idle("random");

    // Reset in the cycle after a read: the returning word must be dropped
    @(negedge clk);
    push_word(32'hDEAD_BEEF, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #4;
      if (fifo_re_o) found = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrst_no_read: got no fifo_re_o expected one");
    end
    rst_n_i = 1'b0;
    exp_q.delete(); fifo_q.delete();
    model_wc = 16'd0; mon_pkts = 16'd0; outstanding = 0;
    #4;
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_re", 64'(fifo_re_o), 64'd0);
    chk("midrst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
    @(negedge clk);
    @(negedge clk); rst_n_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #4;
      chk("midrst_drop_valid", 64'(valid_o), 64'd0);
      @(negedge clk);
    end

    // Wrap: 65536 single-word packets bring the counter back to 0
    ready_i = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      push_word($urandom, 1'b1);
      @(negedge clk);
    end
    wait_idle("wrap");
    chk("wrap_pkt_cnt", 64'(pkt_cnt_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
